// File: rtl/hrv_rmssd_stream.sv
// Streaming RMSSD engine: accumulates squared successive RR differences over
// 2^LOG2_N diffs, then floor(sqrt(mean)) bit-serially. Optional pNN counter: RMSSD_PNN_EN.
module hrv_rmssd_stream #(
  parameter int RR_W       = 12,
  parameter int LOG2_N     = 3,
  parameter int CONTINUOUS = 0,
  parameter int PNN_THRESH = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RR_W-1:0]   rr_in,
  input  logic              rr_valid,
  output logic              rr_ready,
  output logic [RR_W-1:0]   rmssd_out,
  output logic              done,
  output logic              busy,
  output logic [LOG2_N:0]   pnn_count
);

  localparam int ACC_W = 2*RR_W + LOG2_N;
  localparam int SQ_W  = 2*RR_W;
  localparam int REM_W = RR_W + 2;
  localparam int BIT_W = $clog2(RR_W);
  localparam logic [LOG2_N:0]  CNT_LAST = (LOG2_N+1)'((1 << LOG2_N) - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(RR_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SQRT, S_DONE} state_t;

  state_t            r_state;
  logic [RR_W-1:0]   r_rr_prev;
  logic [ACC_W-1:0]  r_acc;
  logic [LOG2_N:0]   r_cnt;
  logic              r_first;
  logic [SQ_W-1:0]   r_m;
  logic [REM_W-1:0]  r_rem;
  logic [RR_W-1:0]   r_root;
  logic [BIT_W-1:0]  r_bit;
  logic              r_sq_load;
  logic [RR_W-1:0]   r_rmssd;
  logic              r_done;

  logic              w_accept;
  logic              w_lt;
  logic [RR_W-1:0]   w_diff;
  logic [SQ_W-1:0]   w_sq;
  logic [REM_W+1:0]  w_rem_sh;
  logic [REM_W+1:0]  w_trial;
  logic              w_ge;
  logic [REM_W-1:0]  w_rem_nx;
  logic [RR_W-1:0]   w_root_nx;
  logic              w_sqrt_last;

  assign rr_ready  = (r_state == S_ACC);
  assign busy      = (r_state == S_ACC) || (r_state == S_SQRT);
  assign rmssd_out = r_rmssd;
  assign done      = r_done;

  assign w_accept = rr_valid && rr_ready;
  // Absolute difference picked by ordering, so the subtraction never wraps.
  assign w_lt     = rr_in < r_rr_prev;
  assign w_diff   = w_lt ? (r_rr_prev - rr_in) : (rr_in - r_rr_prev);
  assign w_sq     = SQ_W'(w_diff) * SQ_W'(w_diff);

  // Restoring sqrt step: bring down two operand bits, try subtracting 4*root+1.
  assign w_rem_sh    = {r_rem, r_m[SQ_W-1 -: 2]};
  assign w_trial     = {2'b00, r_root, 2'b01};
  assign w_ge        = (w_rem_sh >= w_trial);
  assign w_rem_nx    = REM_W'(w_ge ? (w_rem_sh - w_trial) : w_rem_sh);
  assign w_root_nx   = {r_root[RR_W-2:0], w_ge};
  assign w_sqrt_last = (r_state == S_SQRT) && !r_sq_load && (r_bit == '0);

  // NOTE: state registers take non-blocking assignments only, so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_prev <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b1;
      r_m       <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_bit     <= '0;
      r_sq_load <= 1'b0;
      r_rmssd   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_first <= 1'b1;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_rr_prev <= rr_in;
            if (r_first) begin
              r_first <= 1'b0;
            end else begin
              r_acc <= r_acc + ACC_W'(w_sq);
              r_cnt <= r_cnt + (LOG2_N+1)'(1);
              if (r_cnt == CNT_LAST) begin
                r_state   <= S_SQRT;
                r_sq_load <= 1'b1;
              end
            end
          end
        end
        S_SQRT: begin
          if (r_sq_load) begin
            r_sq_load <= 1'b0;
            r_m       <= r_acc[ACC_W-1:LOG2_N];
            r_rem     <= '0;
            r_root    <= '0;
            r_bit     <= BIT_TOP;
          end else begin
            r_rem  <= w_rem_nx;
            r_root <= w_root_nx;
            r_m    <= {r_m[SQ_W-3:0], 2'b00};
            r_bit  <= r_bit - BIT_W'(1);
            if (w_sqrt_last) begin
              r_rmssd <= w_root_nx;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_acc <= '0;
          r_cnt <= '0;
          // Chained frames keep rr_prev so the next sample yields a difference.
          if (CONTINUOUS != 0) begin
            r_first <= 1'b0;
            r_state <= S_ACC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RMSSD_PNN_EN
  localparam logic [RR_W-1:0] PNN_T = RR_W'(PNN_THRESH);
  logic [LOG2_N:0] r_pnn_acc;
  logic [LOG2_N:0] r_pnn_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pnn_acc <= '0;
      r_pnn_out <= '0;
    end else begin
      if ((r_state == S_IDLE && start) || r_state == S_DONE)
        r_pnn_acc <= '0;
      else if (w_accept && !r_first && (w_diff > PNN_T))
        r_pnn_acc <= r_pnn_acc + (LOG2_N+1)'(1);
      if (w_sqrt_last)
        r_pnn_out <= r_pnn_acc;
    end
  end

  assign pnn_count = r_pnn_out;
`else
  assign pnn_count = '0;
`endif

endmodule

// File: tb/tb_hrv_rmssd_stream.sv
// Directed bench for hrv_rmssd_stream: single-frame DUT driven from a vector
// table, plus a CONTINUOUS=1 DUT and reset / ignored-input sequences.
module tb_hrv_rmssd_stream;
  localparam int RR_W = 12;
  localparam int LAT  = RR_W + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [RR_W-1:0] rr_in;
  logic [1:0]      start_v, valid_v, ready_v, done_v, busy_v;
  logic [RR_W-1:0] rmssd0, rmssd1;
  logic [3:0]      pnn0, pnn1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hrv_rmssd_stream #(.RR_W(RR_W), .LOG2_N(3), .CONTINUOUS(0), .PNN_THRESH(50)) dut_s (
    .clk(clk), .rst(rst), .start(start_v[0]), .rr_in(rr_in), .rr_valid(valid_v[0]),
    .rr_ready(ready_v[0]), .rmssd_out(rmssd0), .done(done_v[0]), .busy(busy_v[0]),
    .pnn_count(pnn0));

  hrv_rmssd_stream #(.RR_W(RR_W), .LOG2_N(3), .CONTINUOUS(1), .PNN_THRESH(50)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[1]), .rr_in(rr_in), .rr_valid(valid_v[1]),
    .rr_ready(ready_v[1]), .rmssd_out(rmssd1), .done(done_v[1]), .busy(busy_v[1]),
    .pnn_count(pnn1));

  typedef struct {
    logic [8:0][RR_W-1:0] s;     // first sample sits in s[8]
    logic [RR_W-1:0]      rmssd;
    logic [3:0]           pnn;
    bit                   gap;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [9*RR_W-1:0] s, input logic [RR_W-1:0] r,
                         input logic [3:0] p, input bit g);
    vecs[i].s = s; vecs[i].rmssd = r; vecs[i].pnn = p; vecs[i].gap = g;
  endtask

  function automatic logic [3:0] pnn_exp(input logic [3:0] p);
`ifdef RMSSD_PNN_EN
    return p;
`else
    return 4'd0;
`endif
  endfunction

  task automatic start_frame(input int d);
    @(posedge clk); #1 start_v[d] = 1'b1;
    @(posedge clk); #1 start_v[d] = 1'b0;
  endtask

  // Holds the sample until accepted; returns #1 after the accepting edge.
  task automatic send(input int d, input logic [RR_W-1:0] v);
    bit ok = 1'b0;
    rr_in = v;
    valid_v[d] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready_v[d]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 valid_v[d] = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout dut%0d: rr_ready never seen, expected 1", d);
    end
  endtask

  task automatic wait_done(input int d, output int edges);
    edges = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done_v[d]) begin edges = k; break; end
    end
  endtask

  task automatic run_vec(input int i);
    int e;
    start_frame(0);
    for (int j = 0; j < 9; j++) begin
      send(0, vecs[i].s[8-j]);
      if (vecs[i].gap && j < 8) begin
        @(posedge clk); #1;
        check($sformatf("v%0d_ready_in_gap", i), ready_v[0], 1);
      end
    end
    check($sformatf("v%0d_sqrt_ready", i), ready_v[0], 0);
    check($sformatf("v%0d_sqrt_busy", i), busy_v[0], 1);
    wait_done(0, e);
    check($sformatf("v%0d_latency", i), e, LAT);
    check($sformatf("v%0d_rmssd", i), rmssd0, vecs[i].rmssd);
    check($sformatf("v%0d_pnn", i), pnn0, pnn_exp(vecs[i].pnn));
    check($sformatf("v%0d_busy_done", i), busy_v[0], 0);
    @(posedge clk); #1;
    check($sformatf("v%0d_done_pulse", i), done_v[0], 0);
    check($sformatf("v%0d_busy_after", i), busy_v[0], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int e;
    rst = 1'b1; start_v = '0; valid_v = '0; rr_in = '0;

    set_vec(0, {9{12'd800}}, 12'd0, 4'd0, 1'b0);
    set_vec(1, {12'd800,12'd810,12'd800,12'd810,12'd800,12'd810,12'd800,12'd810,12'd800}, 12'd10, 4'd0, 1'b0);
    set_vec(2, {12'd800,12'd810,12'd800,12'd810,12'd800,12'd810,12'd800,12'd810,12'd800}, 12'd10, 4'd0, 1'b1);
    set_vec(3, {12'd800,12'd810,12'd800,12'd810,12'd800,12'd810,12'd800,12'd810,12'd801}, 12'd9, 4'd0, 1'b0);
    set_vec(4, {12'd0,12'd4095,12'd0,12'd4095,12'd0,12'd4095,12'd0,12'd4095,12'd0}, 12'd4095, 4'd8, 1'b0);
    set_vec(5, {12'd800,12'd860,12'd820,12'd880,12'd840,12'd900,12'd860,12'd920,12'd880}, 12'd50, 4'd4, 1'b0);
    set_vec(6, {12'd800,12'd850,12'd800,12'd850,12'd800,12'd850,12'd800,12'd850,12'd800}, 12'd50, 4'd0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_rmssd", rmssd0, 0);
    check("rst_done", done_v[0], 0);
    check("rst_busy", busy_v[0], 0);
    check("rst_ready", ready_v[0], 0);
    check("rst_pnn", pnn0, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // rr_valid in IDLE is ignored and nothing starts.
    rr_in = 12'd4000; valid_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_valid_busy", busy_v[0], 0);
    check("idle_valid_rmssd", rmssd0, 50);
    valid_v[0] = 1'b0;

    // Reset mid-frame after five accepts.
    start_frame(0);
    for (int j = 0; j < 5; j++) send(0, 12'(900 + 40*j));
    rst = 1'b1;
    #2;
    check("midrst_rmssd", rmssd0, 0);
    check("midrst_busy", busy_v[0], 0);
    check("midrst_ready", ready_v[0], 0);
    check("midrst_done", done_v[0], 0);
    check("midrst_pnn", pnn0, 0);
    @(posedge clk); #1 rst = 1'b0;
    start_frame(0);
    for (int j = 0; j < 9; j++) send(0, 12'd1000);
    wait_done(0, e);
    check("postrst_latency", e, LAT);
    check("postrst_rmssd", rmssd0, 0);

    // Chained frames: 17 alternating samples, stray start inside frame two.
    start_frame(1);
    for (int j = 0; j < 9; j++) send(1, (j % 2) ? 12'd810 : 12'd800);
    wait_done(1, e);
    check("cont_f1_latency", e, LAT);
    check("cont_f1_rmssd", rmssd1, 10);
    @(posedge clk); #1;
    check("cont_back_to_acc", ready_v[1], 1);
    check("cont_busy", busy_v[1], 1);
    for (int j = 9; j < 17; j++) begin
      if (j == 12) begin
        start_v[1] = 1'b1;
        @(posedge clk); #1 start_v[1] = 1'b0;
      end
      send(1, (j % 2) ? 12'd810 : 12'd800);
    end
    wait_done(1, e);
    check("cont_f2_latency", e, LAT);
    check("cont_f2_rmssd", rmssd1, 10);
    check("cont_f2_pnn", pnn1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
